// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// datapath width, CALC step count and a two's-complement magnitude helper.
package sequential_divider_pkg;

   localparam int DIV_WIDTH = 32;

   // CALC runs from STEP_LAST down to 0 inclusive, i.e. DIV_WIDTH steps.
   localparam logic [4:0] STEP_LAST = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Unsigned magnitude; the most negative value maps to 2^(DIV_WIDTH-1).
   function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v);
      return v[DIV_WIDTH-1] ? -v : v;
   endfunction

endpackage

// File: rtl/sequential_divider_ripple_carry.sv
// Ripple-carry adder used for the divider's trial subtraction
// (sum = a + b + cin, cout is the carry out of the top bit).
module ripple_carry #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   // Carry chain kept in a process-local variable so each stage is a
   // separate combinational node rather than a self-referencing vector.
   always_comb begin
      logic carry;
      carry = cin_i;
      sum_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry;
   end

endmodule

// File: rtl/sequential_divider.sv
// Sequential signed divider: one restoring step per clock on operand magnitudes,
// sign fix-up afterwards; fixed latency regardless of operands.
module sequential_divider
   import sequential_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   state_e           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] bmag_q, bmag_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] rem_shift;
   logic [WIDTH-1:0] trial_diff;
   logic             trial_carry;

   // Partial remainder stays below |B| <= 2^(WIDTH-1), so the shifted value fits WIDTH bits.
   assign rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

   ripple_carry #(
      .WIDTH (WIDTH)
   ) u_trial_sub (
      .a_i    (rem_shift),
      .b_i    (~bmag_q),
      .cin_i  (1'b1),
      .sum_o  (trial_diff),
      .cout_o (trial_carry)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      bmag_d  = bmag_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               quo_d   = magnitude(A);
               bmag_d  = magnitude(B);
               a_neg_d = A[WIDTH-1];
               b_neg_d = B[WIDTH-1];
               rem_d   = '0;
               cnt_d   = STEP_LAST;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            busy  = 1'b1;
            rem_d = trial_carry ? trial_diff : rem_shift;
            quo_d = {quo_q[WIDTH-2:0], trial_carry};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            busy = 1'b1;
            // A zero divisor gets a fixed -1 / A result instead of the raw restoring output.
            if (b_q == '0) begin
               q_d   = '1;
               r_d   = a_q;
               dbz_d = 1'b1;
            end else begin
               q_d   = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
               r_d   = a_neg_q ? -rem_q : rem_q;
               dbz_d = 1'b0;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         bmag_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         bmag_q  <= bmag_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign q           = q_q;
   assign r           = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and random checks for sequential_divider; cycle 1 is the cycle in
// which start is sampled, so done is expected in cycle 35.
module tb_sequential_divider;

   localparam int W = 32;
   localparam int LATENCY = 35;
   localparam int MIN_INT = int'(32'h8000_0000);

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         div_by_zero;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] hold_q   = '0;
   logic [W-1:0] hold_r   = '0;
   logic         hold_dbz = 1'b0;

   always #5 clk = ~clk;

   sequential_divider #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .A           (a),
      .B           (b),
      .busy        (busy),
      .done        (done),
      .q           (q),
      .r           (r),
      .div_by_zero (div_by_zero)
   );

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One division; poke re-asserts start with 1/1 in mid-CALC, which must be ignored.
   task automatic run_div(input string tag, input int av, input int bv, input int eq,
                          input int er, input bit edbz, input bit poke);
      int cyc;
      int extra;
      bit seen;
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      cyc   = 1;
      seen  = 1'b0;
      while (!seen && cyc < LATENCY + 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 2) begin
            start = 1'b0;
            a     = ~av;
            b     = ~bv;
         end
         if (poke && cyc == 6) begin
            start = 1'b1;
            a     = 1;
            b     = 1;
         end
         if (poke && cyc == 7) start = 1'b0;
         if (cyc == 10) begin
            check_eq({tag, " busy_calc"}, 32'(busy), 32'd1);
            check_eq({tag, " q_hold"}, q, hold_q);
            check_eq({tag, " r_hold"}, r, hold_r);
            check_eq({tag, " dbz_hold"}, 32'(div_by_zero), 32'(hold_dbz));
         end
         if (done) seen = 1'b1;
      end
      check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
      check_eq({tag, " latency"}, 32'(cyc), 32'(LATENCY));
      check_eq({tag, " busy_at_done"}, 32'(busy), 32'd0);
      check_eq({tag, " q"}, q, 32'(eq));
      check_eq({tag, " r"}, r, 32'(er));
      check_eq({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
      $display("%s: A=%0d B=%0d q=%0d r=%0d dbz=%0b cycles=%0d",
               tag, av, bv, $signed(q), $signed(r), div_by_zero, cyc);
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) extra++;
      end
      check_eq({tag, " single_pulse"}, 32'(extra), 32'd0);
      check_eq({tag, " q_after"}, q, 32'(eq));
      hold_q   = q;
      hold_r   = r;
      hold_dbz = div_by_zero;
      hold_q   = 32'(eq);
      hold_r   = 32'(er);
      hold_dbz = edbz;
   endtask

   initial begin
      int     av;
      int     bv;
      int     eq;
      int     er;
      longint la;
      longint lb;
      bit     seen;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      check_eq("reset busy", 32'(busy), 32'd0);
      check_eq("reset done", 32'(done), 32'd0);
      check_eq("reset q", q, 32'd0);
      check_eq("reset r", r, 32'd0);
      check_eq("reset dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_div("100/7",     100,     7,  14,  2, 1'b0, 1'b0);
      run_div("-100/7",   -100,     7, -14, -2, 1'b0, 1'b0);
      run_div("100/-7",    100,    -7, -14,  2, 1'b0, 1'b0);
      run_div("-100/-7",  -100,    -7,  14, -2, 1'b0, 1'b0);
      run_div("min/-1",  MIN_INT,  -1, MIN_INT, 0, 1'b0, 1'b0);
      run_div("min/1",   MIN_INT,   1, MIN_INT, 0, 1'b0, 1'b0);
      run_div("5/0",         5,     0,  -1,  5, 1'b1, 1'b0);
      run_div("-5/0",       -5,     0,  -1, -5, 1'b1, 1'b0);
      run_div("7/100",       7,   100,   0,  7, 1'b0, 1'b0);
      run_div("100/7 poke", 100,    7,  14,  2, 1'b0, 1'b1);

      // Abort a division partway through CALC with an asynchronous reset.
      @(negedge clk);
      a     = 100;
      b     = 7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort busy", 32'(busy), 32'd0);
      check_eq("abort done", 32'(done), 32'd0);
      check_eq("abort q", q, 32'd0);
      check_eq("abort r", r, 32'd0);
      check_eq("abort dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check_eq("abort no_done", 32'(seen), 32'd0);
      $display("abort: reset during CALC, done_seen=%0b", seen);
      hold_q   = '0;
      hold_r   = '0;
      hold_dbz = 1'b0;
      run_div("9/3", 9, 3, 3, 0, 1'b0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 3))
            0: begin
               av = $urandom;
               bv = $urandom;
            end
            1: begin
               av = $urandom;
               bv = int'($urandom_range(0, 20)) - 10;
            end
            2: begin
               av = int'($urandom_range(0, 2000)) - 1000;
               bv = int'($urandom_range(0, 60)) - 30;
            end
            default: begin
               av = MIN_INT + int'($urandom_range(0, 3));
               bv = int'($urandom >> $urandom_range(0, 31));
            end
         endcase
         la = longint'(av);
         lb = longint'(bv);
         if (lb == 0) begin
            eq = -1;
            er = av;
         end else begin
            eq = int'(la / lb);
            er = int'(la % lb);
         end
         run_div($sformatf("rand%0d", i), av, bv, eq, er, bv == 0, 1'b0);
         if (bv != 0) begin
            check_eq($sformatf("rand%0d identity", i), 32'(int'(q) * bv + int'(r)), 32'(av));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
